// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and baud divisor helper for the UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable by clr.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart on clr, wrap after the last clock of a tick period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampling, 3-sample majority vote,
// false-start rejection and separate parity / framing error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 rx_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_err,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == PAR_ODD);

  // The PARITY parameter hides the imported state name, so states are
  // referenced with the package scope throughout.
  rx_state_t state_q, state_d;

  logic                 sync1_q, sync2_q, sync3_q;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;

  logic tick, tick_clr, fall, vote, mid, bit_end;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .arst (arst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign fall    = sync3_q & ~sync2_q;
  assign vote    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign mid     = tick && (scnt_q == S_V2);
  assign bit_end = tick && (scnt_q == S_END);

  // Two-flop synchroniser plus edge-history flop; idle-high so reset never fakes a start.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) {sync1_q, sync2_q, sync3_q} <= 3'b111;
    else      {sync1_q, sync2_q, sync3_q} <= {rx_in, sync1_q, sync2_q};
  end

  // Next-state, sampling, shifting and flag logic.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    data_d     = data_q;
    done_d     = 1'b0;
    pe_d       = 1'b0;
    fe_d       = 1'b0;
    tick_clr   = 1'b0;

    if (state_q != uart_pkg::IDLE && !rx_en) begin
      state_d = uart_pkg::IDLE;
    end else if (state_q == uart_pkg::IDLE) begin
      if (fall && rx_en) begin
        state_d    = uart_pkg::START;
        tick_clr   = 1'b1;
        scnt_d     = '0;
        bcnt_d     = '0;
        par_bad_d  = 1'b0;
        stop_bad_d = 1'b0;
      end
    end else if (tick) begin
      scnt_d = (scnt_q == S_END) ? '0 : scnt_q + 1'b1;
      if (scnt_q == S_V0) s0_d = sync2_q;
      if (scnt_q == S_V1) s1_d = sync2_q;
      case (state_q)
        uart_pkg::START: begin
          if (mid && vote)  state_d = uart_pkg::IDLE;
          else if (bit_end) state_d = uart_pkg::DATA;
        end
        uart_pkg::DATA: begin
          if (mid) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bcnt_q == B_LAST) begin
              bcnt_d  = '0;
              state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : uart_pkg::STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (mid)     par_bad_d = vote ^ (^shift_q) ^ ODD;
          if (bit_end) state_d   = uart_pkg::STOP;
        end
        uart_pkg::STOP: begin
          if (mid) begin
            if (bcnt_q == STOP_LAST) begin
              state_d = uart_pkg::IDLE;
              done_d  = 1'b1;
              data_d  = shift_q;
              pe_d    = par_bad_q;
              fe_d    = stop_bad_q | ~vote;
            end else begin
              stop_bad_d = stop_bad_q | ~vote;
            end
          end
          if (bit_end) bcnt_d = bcnt_q + 1'b1;
        end
        default: state_d = uart_pkg::IDLE;
      endcase
    end
  end

  // State, counter, shift and output flag registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= uart_pkg::IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      data_q     <= data_d;
      done_q     <= done_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_done    = done_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign rx_err     = pe_q | fe_q;
  assign rx_busy    = (state_q != uart_pkg::IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance and 7E2 instance, with a
// scoreboard of expected frames checked whenever rx_done pulses.
`timescale 1ns/1ps
module tb_uart_rx_param;

  // 100 MHz clock, 781250 baud, 16x -> 8 clocks per tick, 1280 ns per bit.
  localparam int unsigned CLKF   = 100_000_000;
  localparam int unsigned BAUDR  = 781_250;
  localparam int          BIT    = 1280;
  localparam int          SPK_AT = 680;  // 8.5/16 of a bit
  localparam int          SPK_W  = 80;   // one sample period

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic en = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [7:0] data_a;
  logic       done_a, err_a, pe_a, fe_a, busy_a;
  logic [6:0] data_b;
  logic       done_b, err_b, pe_b, fe_b, busy_b;

  exp_t qa[$];
  exp_t qb[$];
  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned done_a_n = 0, done_b_n = 0;
  int unsigned exp_a_n  = 0, exp_b_n  = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .arst(arst), .rx_en(en), .rx_in(rx_a),
    .rx_data(data_a), .rx_done(done_a), .rx_err(err_a),
    .parity_err(pe_a), .frame_err(fe_a), .rx_busy(busy_a)
  );

  uart_rx_param #(
    .CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .arst(arst), .rx_en(en), .rx_in(rx_b),
    .rx_data(data_b), .rx_done(done_b), .rx_err(err_b),
    .parity_err(pe_b), .frame_err(fe_b), .rx_busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 8N1 frame; spike_bit inverts one sample at that bit's centre,
  // abort_bit drops rx_en in the middle of that bit.
  task automatic send_a(input logic [7:0] d, input logic stop,
                        input int spike_bit, input int abort_bit);
    @(negedge clk);
    rx_a = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      if (i == spike_bit) begin
        #(SPK_AT); rx_a = ~d[i]; #(SPK_W); rx_a = d[i]; #(BIT - SPK_AT - SPK_W);
      end else if (i == abort_bit) begin
        #(BIT / 2); en = 1'b0; #(BIT / 2);
      end else begin
        #(BIT);
      end
    end
    rx_a = stop;
    #(BIT);
    rx_a = 1'b1;
  endtask

  task automatic expect_a(input logic [7:0] d, input logic stop);
    qa.push_back('{d: {1'b0, d}, pe: 1'b0, fe: ~stop});
    exp_a_n++;
  endtask

  // 7-bit even-parity, 2-stop frame with explicit parity and stop values.
  task automatic send_b(input logic [6:0] d, input logic par, input logic stop1, input logic stop2);
    qb.push_back('{d: {2'b00, d}, pe: (par != ^d), fe: ~(stop1 & stop2)});
    exp_b_n++;
    @(negedge clk);
    rx_b = 1'b0;
    #(BIT);
    for (int i = 0; i < 7; i++) begin
      rx_b = d[i];
      #(BIT);
    end
    rx_b = par;   #(BIT);
    rx_b = stop1; #(BIT);
    rx_b = stop2; #(BIT);
    rx_b = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", qa.size() + qb.size(), 0);
  endtask

  initial begin
    exp_t e;

    // Scoreboard monitor: every rx_done pops and checks one expected frame.
    fork
      forever begin
        @(negedge clk);
        if (done_a) begin
          done_a_n++;
          if (qa.size() == 0) begin
            chk("a_unexpected_done", 1, 0);
          end else begin
            e = qa.pop_front();
            chk("a_data", data_a, e.d[7:0]);
            chk("a_parity_err", pe_a, e.pe);
            chk("a_frame_err", fe_a, e.fe);
            chk("a_rx_err", err_a, e.pe | e.fe);
            chk("a_busy_at_done", busy_a, 0);
          end
        end
        if (done_b) begin
          done_b_n++;
          if (qb.size() == 0) begin
            chk("b_unexpected_done", 1, 0);
          end else begin
            e = qb.pop_front();
            chk("b_data", data_b, e.d[6:0]);
            chk("b_parity_err", pe_b, e.pe);
            chk("b_frame_err", fe_b, e.fe);
            chk("b_rx_err", err_b, e.pe | e.fe);
            chk("b_busy_at_done", busy_b, 0);
          end
        end
      end
    join_none

    // Reset state
    #23;
    chk("rst_data", data_a, 0);
    chk("rst_flags", {done_a, err_a, pe_a, fe_a, busy_a}, 0);
    chk("rst_b_flags", {data_b, done_b, err_b, pe_b, fe_b, busy_b}, 0);
    arst = 1'b0;
    #(2 * BIT);

    // 8N1 basic frame
    expect_a(8'h0F, 1'b1);
    send_a(8'h0F, 1'b1, -1, -1);
    drain();
    #(BIT);
    chk("a_0F_done_count", done_a_n, exp_a_n);
    chk("a_0F_busy_after", busy_a, 0);

    // 7E2: wrong parity, correct parity, second stop bit low
    send_b(7'h55, 1'b1, 1'b1, 1'b1);
    send_b(7'h55, 1'b0, 1'b1, 1'b1);
    send_b(7'h2B, 1'b0, 1'b1, 1'b0);
    drain();
    #(BIT);
    chk("b_done_count", done_b_n, exp_b_n);

    // Framing error, then idle line: no second frame
    expect_a(8'hA5, 1'b0);
    send_a(8'hA5, 1'b0, -1, -1);
    drain();
    #(4 * BIT);
    chk("a_ferr_no_spurious", done_a_n, exp_a_n);

    // Majority vote rejects a one-sample spike in data bit 3
    expect_a(8'h00, 1'b1);
    send_a(8'h00, 1'b1, 3, -1);
    drain();
    #(BIT);

    // Start glitch of 3/16 bit: busy rises 3 clocks after the edge, then drops
    @(negedge clk);
    rx_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("glitch_busy_2clk", busy_a, 0);
    @(posedge clk);
    #1 chk("glitch_busy_3clk", busy_a, 1);
    #(240 - 26);
    rx_a = 1'b1;
    #(2 * BIT);
    chk("glitch_busy_dropped", busy_a, 0);
    chk("glitch_no_done", done_a_n, exp_a_n);
    expect_a(8'h3C, 1'b1);
    send_a(8'h3C, 1'b1, -1, -1);
    drain();
    #(BIT);

    // Abort via rx_en in the middle of data bit 4
    send_a(8'h5A, 1'b1, -1, 4);
    chk("abort_busy", busy_a, 0);
    #(2 * BIT);
    chk("abort_no_done", done_a_n, exp_a_n);
    chk("abort_data_held", data_a, 8'h3C);
    en = 1'b1;
    #(BIT);

    // Back-to-back frames with no idle gap
    expect_a(8'h12, 1'b1);
    expect_a(8'h34, 1'b1);
    send_a(8'h12, 1'b1, -1, -1);
    send_a(8'h34, 1'b1, -1, -1);
    drain();
    #(BIT);
    chk("b2b_done_count", done_a_n, exp_a_n);

    // Asynchronous reset in the middle of data bit 5 of 0xF0
    fork
      send_a(8'hF0, 1'b1, -1, -1);
      begin
        #(6 * BIT + BIT / 2 + 3);
        chk("pre_arst_busy", busy_a, 1);
        arst = 1'b1;
        #10;
        chk("arst_outputs", {data_a, done_a, err_a, pe_a, fe_a, busy_a}, 0);
        #10;
        arst = 1'b0;
      end
    join
    #(2 * BIT);
    chk("arst_no_done", done_a_n, exp_a_n);
    chk("arst_data_zero", data_a, 0);

    // Recovery after reset
    expect_a(8'hC3, 1'b1);
    send_a(8'hC3, 1'b1, -1, -1);
    drain();
    #(BIT);
    chk("final_done_count", done_a_n, exp_a_n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
